// File: rtl/decoder_scan_seq_pkg.sv
// decoder_scan_seq_pkg: shared state encoding and default widths for the channel scanner
package decoder_scan_seq_pkg;
   localparam int SEL_W_DEF   = 3;
   localparam int DWELL_W_DEF = 8;
   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
endpackage

// File: rtl/decoder_scan_seq_if.sv
// decoder_scan_seq_if: control and select bundle between scan controller and its user
interface decoder_scan_seq_if #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
);
   logic                  start;
   logic                  stop;
   logic                  mode_cont;
   logic [DWELL_W-1:0]    dwell;
   logic [2**SEL_W-1:0]   mask;
   logic [SEL_W-1:0]      sel_out;
   logic                  sel_valid;
   logic                  busy;
   logic                  done;
   logic [7:0]            pass_cnt;
   modport master (output start, stop, mode_cont, dwell, mask,
                   input  sel_out, sel_valid, busy, done, pass_cnt);
   modport slave  (input  start, stop, mode_cont, dwell, mask,
                   output sel_out, sel_valid, busy, done, pass_cnt);
endinterface

// File: rtl/next_chan_find.sv
// next_chan_find: next enabled channel above cur, plus lowest enabled channel in mask
import decoder_scan_seq_pkg::*;
module next_chan_find #(
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic [2**SEL_W-1:0] mask,
   input  logic [SEL_W-1:0]    cur,
   output logic [SEL_W-1:0]    nxt,
   output logic                found,
   output logic [SEL_W-1:0]    first
);
   // descending scan so the last hit is the lowest qualifying channel
   always_comb begin
      nxt   = '0;
      found = 1'b0;
      first = '0;
      for (int i = 2**SEL_W-1; i >= 0; i--) begin
         if (mask[i]) first = SEL_W'(i);
         if (mask[i] && i > int'(cur)) begin
            nxt   = SEL_W'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: steps the decoder select through masked channels with a programmable dwell
import decoder_scan_seq_pkg::*;
module decoder_scan_seq #(
   parameter int SEL_W   = SEL_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input logic              clk,
   input logic              rst,
   decoder_scan_seq_if.slave bus
);
   state_t               state;
   logic                 mode_q;
   logic [DWELL_W-1:0]   last_q;
   logic [DWELL_W-1:0]   cnt;
   logic [2**SEL_W-1:0]  mask_q;
   logic [SEL_W-1:0]     sel_q;
   logic                 valid_q;
   logic                 busy_q;
   logic                 done_q;
   logic [7:0]           pass_q;
   logic [2**SEL_W-1:0]  find_mask;
   logic [SEL_W-1:0]     nxt;
   logic [SEL_W-1:0]     first;
   logic                 found;
   // in IDLE the finder looks at the live mask to pick the first channel at start
   assign find_mask = (state == IDLE) ? bus.mask : mask_q;
   next_chan_find #(.SEL_W(SEL_W)) u_find (
      .mask  (find_mask),
      .cur   (sel_q),
      .nxt   (nxt),
      .found (found),
      .first (first)
   );
   // storing D-1 keeps the dwell compare inside DWELL_W bits even for dwell=max
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mode_q  <= 1'b0;
         last_q  <= '0;
         cnt     <= '0;
         mask_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            if (bus.start && !bus.stop && |bus.mask) begin
               state   <= SCAN;
               mode_q  <= bus.mode_cont;
               last_q  <= (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
               mask_q  <= bus.mask;
               cnt     <= '0;
               pass_q  <= '0;
               sel_q   <= first;
               valid_q <= 1'b1;
               busy_q  <= 1'b1;
            end
         end else if (bus.stop) begin
            state   <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else if (cnt == last_q) begin
            cnt <= '0;
            if (found) begin
               sel_q <= nxt;
            end else begin
               pass_q <= pass_q + 8'd1;
               if (mode_q) begin
                  sel_q <= first;
               end else begin
                  state   <= IDLE;
                  sel_q   <= '0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
   assign bus.sel_out   = sel_q;
   assign bus.sel_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass_cnt  = pass_q;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// tb_decoder_scan_seq: table-driven single-pass vectors plus directed corner sequences
module tb_decoder_scan_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   decoder_scan_seq_if #(.SEL_W(3), .DWELL_W(8)) bus ();
   decoder_scan_seq #(.SEL_W(3), .DWELL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [7:0]      mask;
      logic [7:0]      dwell;
      int              n;
      int              d;
      logic [7:0][2:0] chans;
   } vec_t;
   vec_t vecs[5];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic chk_idle(input string nm);
      chk({nm, ".valid"}, 32'(bus.sel_valid), 0);
      chk({nm, ".busy"}, 32'(bus.busy), 0);
      chk({nm, ".sel"}, 32'(bus.sel_out), 0);
   endtask
   task automatic pulse_start(input logic [7:0] m, input logic [7:0] dw, input logic mc);
      bus.mask = m;
      bus.dwell = dw;
      bus.mode_cont = mc;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic run_vec(input vec_t v, input int id);
      pulse_start(v.mask, v.dwell, 1'b0);
      for (int k = 0; k < v.n; k++)
         for (int j = 0; j < v.d; j++) begin
            chk($sformatf("v%0d.sel[%0d.%0d]", id, k, j), 32'(bus.sel_out), 32'(v.chans[k]));
            chk($sformatf("v%0d.valid", id), 32'(bus.sel_valid), 1);
            chk($sformatf("v%0d.busy", id), 32'(bus.busy), 1);
            chk($sformatf("v%0d.done_early", id), 32'(bus.done), 0);
            @(negedge clk);
         end
      chk($sformatf("v%0d.done", id), 32'(bus.done), 1);
      chk_idle($sformatf("v%0d.end", id));
      chk($sformatf("v%0d.pass", id), 32'(bus.pass_cnt), 1);
      @(negedge clk);
      chk($sformatf("v%0d.done_once", id), 32'(bus.done), 0);
   endtask
   initial begin
      vecs[0] = '{mask: 8'hFF, dwell: 8'd1, n: 8, d: 1,
                  chans: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
      vecs[1] = '{mask: 8'hA4, dwell: 8'd3, n: 3, d: 3,
                  chans: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2}};
      vecs[2] = '{mask: 8'h81, dwell: 8'd0, n: 2, d: 1,
                  chans: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0}};
      vecs[3] = '{mask: 8'h81, dwell: 8'd1, n: 2, d: 1,
                  chans: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0}};
      vecs[4] = '{mask: 8'h10, dwell: 8'd2, n: 1, d: 2,
                  chans: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}};
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.mode_cont = 1'b0;
      bus.dwell = '0;
      bus.mask = '0;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      chk("reset.done", 32'(bus.done), 0);
      chk("reset.pass", 32'(bus.pass_cnt), 0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
      pulse_start(8'h00, 8'd1, 1'b0);
      chk_idle("mask0");
      chk("mask0.done", 32'(bus.done), 0);
      bus.stop = 1'b1;
      pulse_start(8'hFF, 8'd1, 1'b0);
      bus.stop = 1'b0;
      chk_idle("start_stop");
      pulse_start(8'h03, 8'd2, 1'b1);
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("cont.sel[%0d]", c), 32'(bus.sel_out), 32'((c / 2) % 2));
         chk("cont.valid", 32'(bus.sel_valid), 1);
         chk("cont.done", 32'(bus.done), 0);
         if (c == 5) begin
            bus.start = 1'b1;
            bus.mask = 8'hF0;
            bus.dwell = 8'd5;
            bus.mode_cont = 1'b0;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      chk("cont.pass", 32'(bus.pass_cnt), 5);
      chk("cont.wrap_sel", 32'(bus.sel_out), 0);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      chk_idle("stop");
      chk("stop.done", 32'(bus.done), 0);
      chk("stop.pass", 32'(bus.pass_cnt), 5);
      pulse_start(8'hA4, 8'd3, 1'b0);
      repeat (6) @(negedge clk);
      chk("rst_mid.sel", 32'(bus.sel_out), 7);
      rst = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      rst = 1'b0;
      chk_idle("rst_mid");
      chk("rst_mid.done", 32'(bus.done), 0);
      chk("rst_mid.pass", 32'(bus.pass_cnt), 0);
      run_vec(vecs[0], 5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
